mvm_tile_sequencer: RTL and testbench

// Sequences the mem_controller / mat_vec_mult datapath over a matrix of num_tiles x NUM_MACS rows.
// Per tile: one accumulator clear, a fetch from the tile's base address, then a compute.
// The NUM_MACS results of each tile are streamed out over a valid/ready port.

---
 rtl/mvm_tile_sequencer_if.sv | 35 +++
 rtl/mvm_tile_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_mvm_tile_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_tile_sequencer_if.sv
// Datapath-facing bundle of the tile sequencer: control for the memory
// controller and the MAC array, plus the result stream. The sequencer
// takes the master side; the datapath/result sink takes the slave side.
interface mvm_tile_sequencer_if #(
    parameter int NUM_MACS  = 8,
    parameter int RES_W     = 24,
    parameter int ADDR_W    = 32,
    parameter int MAX_TILES = 16
);
    localparam int IDX_W = $clog2(NUM_MACS * MAX_TILES);

    logic                      mc_start;
    logic [ADDR_W-1:0]         mc_base_addr;
    logic                      mc_done;
    logic                      clr_accum;
    logic                      start_compute;
    logic                      compute_done;
    logic [NUM_MACS*RES_W-1:0] mac_out;
    logic                      res_valid;
    logic                      res_ready;
    logic [IDX_W-1:0]          res_idx;
    logic [RES_W-1:0]          res_data;

    modport master (
        output mc_start, mc_base_addr, clr_accum, start_compute,
               res_valid, res_idx, res_data,
        input  mc_done, compute_done, mac_out, res_ready
    );

    modport slave (
        input  mc_start, mc_base_addr, clr_accum, start_compute,
               res_valid, res_idx, res_data,
        output mc_done, compute_done, mac_out, res_ready
    );
endinterface

// File: rtl/mvm_tile_sequencer.sv
// Multi-tile sequencer for the mem_controller / mat_vec_mult datapath.
// Each tile is cleared, fetched, computed and then its NUM_MACS results are
// streamed out one lane at a time. A watchdog bounds FETCH and COMPUTE.
// Every output is a flop whose next value is derived from the next state.
module mvm_tile_sequencer #(
    parameter int NUM_MACS    = 8,
    parameter int RES_W       = 24,
    parameter int ADDR_W      = 32,
    parameter int MAX_TILES   = 16,
    parameter int TILE_STRIDE = 9,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           go,
    input  logic                           abort,
    input  logic [$clog2(MAX_TILES+1)-1:0] num_tiles,
    input  logic [ADDR_W-1:0]              base_addr,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [$clog2(MAX_TILES)-1:0]   tile_cnt,
    mvm_tile_sequencer_if.master           bus
);
    localparam int NT_W   = $clog2(MAX_TILES + 1);
    localparam int TILE_W = $clog2(MAX_TILES);
    localparam int LANE_W = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1;
    localparam int IDX_W  = $clog2(NUM_MACS * MAX_TILES);
    localparam int WD_W   = $clog2(TIMEOUT_CYC);
    localparam int SNAP_W = NUM_MACS * RES_W;

    typedef enum logic [2:0] {
        IDLE, CLEAR, FETCH, COMPUTE, DRAIN, NEXT, ERROR
    } state_t;

    state_t              state_q, state_n;
    logic [TILE_W-1:0]   tile_q, tile_n;
    logic [LANE_W-1:0]   lane_q, lane_n;
    logic [WD_W-1:0]     wd_q, wd_n;
    logic [NT_W-1:0]     num_q, num_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [SNAP_W-1:0]   snap_q, snap_n;
    logic                err_q, err_n;
    logic                done_n;

    logic                busy_q, done_q;
    logic                clr_q, mc_start_q, start_compute_q, res_valid_q;
    logic [ADDR_W-1:0]   mc_addr_q;
    logic [IDX_W-1:0]    res_idx_q;
    logic [RES_W-1:0]    res_data_q;

    logic                busy_n, clr_n, mc_start_n, start_compute_n, res_valid_n;
    logic [ADDR_W-1:0]   mc_addr_n;
    logic [IDX_W-1:0]    res_idx_n;
    logic [RES_W-1:0]    res_data_n;

    // Next-state logic plus the next value of every registered output.
    always_comb begin
        state_n = state_q;
        tile_n  = tile_q;
        lane_n  = lane_q;
        wd_n    = wd_q;
        num_n   = num_q;
        addr_n  = addr_q;
        snap_n  = snap_q;
        err_n   = err_q;
        done_n  = 1'b0;

        case (state_q)
            IDLE, ERROR: begin
                if (go) begin
                    err_n = 1'b0;
                    if (num_tiles != '0 && num_tiles <= NT_W'(MAX_TILES)) begin
                        num_n   = num_tiles;
                        addr_n  = base_addr;
                        tile_n  = '0;
                        lane_n  = '0;
                        state_n = CLEAR;
                    end else begin
                        // An empty or oversized request completes immediately.
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            CLEAR: begin
                wd_n    = '0;
                state_n = FETCH;
            end
            FETCH: begin
                if (bus.mc_done) begin
                    wd_n    = '0;
                    state_n = COMPUTE;
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    err_n   = 1'b1;
                    state_n = ERROR;
                end else begin
                    wd_n = wd_q + WD_W'(1);
                end
            end
            COMPUTE: begin
                if (bus.compute_done) begin
                    snap_n  = bus.mac_out;
                    lane_n  = '0;
                    wd_n    = '0;
                    state_n = DRAIN;
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    err_n   = 1'b1;
                    state_n = ERROR;
                end else begin
                    wd_n = wd_q + WD_W'(1);
                end
            end
            DRAIN: begin
                if (res_valid_q && bus.res_ready) begin
                    if (lane_q == LANE_W'(NUM_MACS - 1)) begin
                        state_n = NEXT;
                    end else begin
                        lane_n = lane_q + LANE_W'(1);
                    end
                end
            end
            NEXT: begin
                if (NT_W'(tile_q) == num_q - NT_W'(1)) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    tile_n  = tile_q + TILE_W'(1);
                    addr_n  = addr_q + ADDR_W'(TILE_STRIDE);
                    state_n = CLEAR;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort overrides whatever the busy state would have done this cycle.
        if (abort && state_q != IDLE && state_q != ERROR) begin
            state_n = IDLE;
            tile_n  = '0;
            lane_n  = '0;
            wd_n    = '0;
            done_n  = 1'b0;
        end

        busy_n          = (state_n != IDLE) && (state_n != ERROR);
        clr_n           = (state_n == CLEAR);
        mc_start_n      = (state_n == FETCH);
        mc_addr_n       = mc_start_n ? addr_n : '0;
        start_compute_n = (state_n == COMPUTE);
        res_valid_n     = (state_n == DRAIN);
        res_idx_n       = res_valid_n ?
                          IDX_W'(int'(tile_n) * NUM_MACS + int'(lane_n)) : '0;
        res_data_n      = res_valid_n ? snap_n[lane_n*RES_W +: RES_W] : '0;
    end

    // State, counters, snapshot and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            tile_q          <= '0;
            lane_q          <= '0;
            wd_q            <= '0;
            num_q           <= '0;
            addr_q          <= '0;
            snap_q          <= '0;
            err_q           <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            clr_q           <= 1'b0;
            mc_start_q      <= 1'b0;
            mc_addr_q       <= '0;
            start_compute_q <= 1'b0;
            res_valid_q     <= 1'b0;
            res_idx_q       <= '0;
            res_data_q      <= '0;
        end else begin
            state_q         <= state_n;
            tile_q          <= tile_n;
            lane_q          <= lane_n;
            wd_q            <= wd_n;
            num_q           <= num_n;
            addr_q          <= addr_n;
            snap_q          <= snap_n;
            err_q           <= err_n;
            busy_q          <= busy_n;
            done_q          <= done_n;
            clr_q           <= clr_n;
            mc_start_q      <= mc_start_n;
            mc_addr_q       <= mc_addr_n;
            start_compute_q <= start_compute_n;
            res_valid_q     <= res_valid_n;
            res_idx_q       <= res_idx_n;
            res_data_q      <= res_data_n;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
    assign tile_cnt          = tile_q;
    assign bus.clr_accum     = clr_q;
    assign bus.mc_start      = mc_start_q;
    assign bus.mc_base_addr  = mc_addr_q;
    assign bus.start_compute = start_compute_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_idx       = res_idx_q;
    assign bus.res_data      = res_data_q;
endmodule

// File: tb/tb_mvm_tile_sequencer.sv
// Directed bench for mvm_tile_sequencer. A negedge process models the
// memory controller, the MAC array and the result sink; the main thread
// issues runs and compares against hand-computed values.
// MAC lane k of tile t returns t*16 + k + 1, so global index i carries
// (i/8)*16 + (i%8) + 1.
module tb_mvm_tile_sequencer;
    localparam int NUM_MACS    = 8;
    localparam int RES_W       = 24;
    localparam int ADDR_W      = 32;
    localparam int MAX_TILES   = 16;
    localparam int TILE_STRIDE = 9;
    localparam int TIMEOUT_CYC = 64;

    logic        clk = 1'b0;
    logic        rst, go, abort;
    logic [4:0]  num_tiles;
    logic [31:0] base_addr;
    logic        busy, done, err;
    logic [3:0]  tile_cnt;

    mvm_tile_sequencer_if #(
        .NUM_MACS(NUM_MACS), .RES_W(RES_W), .ADDR_W(ADDR_W), .MAX_TILES(MAX_TILES)
    ) bus ();

    mvm_tile_sequencer #(
        .NUM_MACS(NUM_MACS), .RES_W(RES_W), .ADDR_W(ADDR_W), .MAX_TILES(MAX_TILES),
        .TILE_STRIDE(TILE_STRIDE), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort),
        .num_tiles(num_tiles), .base_addr(base_addr),
        .busy(busy), .done(done), .err(err), .tile_cnt(tile_cnt),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    int compare_count  = 0;
    int mismatch_count = 0;

    int mc_delay, cp_delay, mc_cnt, cp_cnt;
    logic mc_hang;
    int ready_mode;
    int stall_left, stall_cycles;
    logic stall_done;
    logic mc_start_prev;
    int clr_cnt, done_cnt;
    logic [6:0]  got_idx[$];
    logic [23:0] got_data[$];
    logic [31:0] base_log[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] n, input logic [31:0] base);
        num_tiles = n;
        base_addr = base;
        go        = 1'b1;
        tick();
        go        = 1'b0;
    endtask

    task automatic clearLogs();
        got_idx.delete();
        got_data.delete();
        base_log.delete();
        clr_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic waitDone(input string tag, input int limit);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < limit) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(done_cnt - d0), 64'd1);
    endtask

    function automatic int exp_data(input int i);
        return (i / 8) * 16 + (i % 8) + 1;
    endfunction

    task automatic checkResults(input string tag, input int n);
        checkOutput({tag, " count"}, 64'(got_idx.size()), 64'(n));
        for (int i = 0; i < n && i < got_idx.size(); i++) begin
            checkOutput($sformatf("%s idx[%0d]", tag, i), 64'(got_idx[i]), 64'(i));
            checkOutput($sformatf("%s data[%0d]", tag, i), 64'(got_data[i]), 64'(exp_data(i)));
        end
    endtask

    task automatic checkBase(input string tag, input int i, input logic [31:0] expected);
        logic [63:0] obs = 'x;
        if (i < base_log.size()) obs = 64'(base_log[i]);
        checkOutput(tag, obs, 64'(expected));
    endtask

    // Datapath model, result sink and event monitors, all at the falling edge.
    initial begin
        bus.mc_done      = 1'b0;
        bus.compute_done = 1'b0;
        bus.mac_out      = '0;
        bus.res_ready    = 1'b1;
        mc_cnt = 0; cp_cnt = 0; stall_left = 0; stall_cycles = 0;
        stall_done = 1'b0; mc_start_prev = 1'b0; clr_cnt = 0; done_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.clr_accum) clr_cnt++;
            if (done) done_cnt++;
            if (bus.mc_start && !mc_start_prev) base_log.push_back(bus.mc_base_addr);
            mc_start_prev = bus.mc_start;

            if (bus.mc_start) mc_cnt++; else mc_cnt = 0;
            bus.mc_done = bus.mc_start && !mc_hang && (mc_cnt == mc_delay);

            if (bus.start_compute) cp_cnt++; else cp_cnt = 0;
            if (bus.start_compute && cp_cnt == cp_delay) begin
                for (int k = 0; k < NUM_MACS; k++)
                    bus.mac_out[k*RES_W +: RES_W] = RES_W'(int'(tile_cnt) * 16 + k + 1);
                bus.compute_done = 1'b1;
            end else begin
                bus.compute_done = 1'b0;
            end

            case (ready_mode)
                1: bus.res_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (bus.res_valid && bus.res_idx == 7'd3 && !stall_done) begin
                        stall_left = 5;
                        stall_done = 1'b1;
                    end
                    if (stall_left > 0) begin
                        bus.res_ready = 1'b0;
                        stall_left--;
                        stall_cycles++;
                        checkOutput("t3 stall valid", 64'(bus.res_valid), 64'd1);
                        checkOutput("t3 stall idx", 64'(bus.res_idx), 64'd3);
                        checkOutput("t3 stall data", 64'(bus.res_data), 64'd4);
                    end else begin
                        bus.res_ready = 1'b1;
                    end
                end
                3: bus.res_ready = 1'b0;
                default: bus.res_ready = 1'b1;
            endcase

            if (bus.res_valid && bus.res_ready && !abort && !rst) begin
                got_idx.push_back(bus.res_idx);
                got_data.push_back(bus.res_data);
            end
        end
    end

    // Main directed sequence.
    initial begin
        int n;
        logic found;
        rst = 1'b1; go = 1'b0; abort = 1'b0; num_tiles = '0; base_addr = '0;
        mc_delay = 5; cp_delay = 3; mc_hang = 1'b0; ready_mode = 0;
        repeat (3) tick();
        checkOutput("rst busy", 64'(busy), 64'd0);
        checkOutput("rst done", 64'(done), 64'd0);
        checkOutput("rst err", 64'(err), 64'd0);
        checkOutput("rst tile_cnt", 64'(tile_cnt), 64'd0);
        checkOutput("rst mc_start", 64'(bus.mc_start), 64'd0);
        checkOutput("rst clr_accum", 64'(bus.clr_accum), 64'd0);
        checkOutput("rst start_compute", 64'(bus.start_compute), 64'd0);
        checkOutput("rst res_valid", 64'(bus.res_valid), 64'd0);
        checkOutput("rst mc_base_addr", 64'(bus.mc_base_addr), 64'd0);
        rst = 1'b0;
        tick();

        // Single tile, fixed latencies, always ready.
        clearLogs();
        mc_delay = 20; cp_delay = 10; ready_mode = 0;
        applyStimulus(5'd1, 32'h100);
        checkOutput("t1 clr at T+1", 64'(bus.clr_accum), 64'd1);
        checkOutput("t1 mc_start at T+1", 64'(bus.mc_start), 64'd0);
        checkOutput("t1 busy at T+1", 64'(busy), 64'd1);
        tick();
        checkOutput("t1 mc_start at T+2", 64'(bus.mc_start), 64'd1);
        checkOutput("t1 clr at T+2", 64'(bus.clr_accum), 64'd0);
        checkOutput("t1 mc_base_addr", 64'(bus.mc_base_addr), 64'h100);
        waitDone("t1 done", 400);
        tick();
        checkOutput("t1 busy after", 64'(busy), 64'd0);
        checkOutput("t1 done count", 64'(done_cnt), 64'd1);
        checkOutput("t1 clr count", 64'(clr_cnt), 64'd1);
        checkResults("t1", 8);

        // Three tiles with a randomly stalling sink.
        clearLogs();
        mc_delay = 5; cp_delay = 3; ready_mode = 1;
        applyStimulus(5'd3, 32'h100);
        waitDone("t2 done", 2000);
        ready_mode = 0;
        checkOutput("t2 clr count", 64'(clr_cnt), 64'd3);
        checkOutput("t2 fetch count", 64'(base_log.size()), 64'd3);
        checkBase("t2 base0", 0, 32'h100);
        checkBase("t2 base1", 1, 32'h109);
        checkBase("t2 base2", 2, 32'h112);
        checkResults("t2", 24);

        // Sink holds ready low for five cycles at lane 3.
        clearLogs();
        stall_done = 1'b0; stall_cycles = 0; ready_mode = 2;
        applyStimulus(5'd1, 32'h200);
        waitDone("t3 done", 400);
        ready_mode = 0;
        checkOutput("t3 stall cycles", 64'(stall_cycles), 64'd5);
        checkResults("t3", 8);

        // Fetch never completes: watchdog fires 64 cycles after mc_start rose.
        clearLogs();
        mc_hang = 1'b1;
        applyStimulus(5'd1, 32'h300);
        tick();
        checkOutput("t4 mc_start rose", 64'(bus.mc_start), 64'd1);
        n = 0;
        while (!err && n < 200) begin
            tick();
            n++;
        end
        checkOutput("t4 cycles to err", 64'(n), 64'd64);
        checkOutput("t4 mc_start dropped", 64'(bus.mc_start), 64'd0);
        checkOutput("t4 busy in error", 64'(busy), 64'd0);
        repeat (3) tick();
        checkOutput("t4 err sticky", 64'(err), 64'd1);
        mc_hang = 1'b0;
        applyStimulus(5'd1, 32'h300);
        checkOutput("t4 err cleared", 64'(err), 64'd0);
        checkOutput("t4 restart clr", 64'(bus.clr_accum), 64'd1);
        waitDone("t4 restart done", 400);
        checkResults("t4 restart", 8);

        // Fetch completes in the very cycle the watchdog would expire.
        clearLogs();
        mc_delay = 64;
        applyStimulus(5'd1, 32'h400);
        waitDone("t4b done", 400);
        checkOutput("t4b no err", 64'(err), 64'd0);
        checkResults("t4b", 8);
        mc_delay = 5;

        // Abort during COMPUTE of tile 1, then restart from tile 0.
        clearLogs();
        cp_delay = 30;
        applyStimulus(5'd3, 32'h500);
        n = 0;
        found = 1'b0;
        while (!found && n < 500) begin
            tick();
            n++;
            found = (tile_cnt == 4'd1) && bus.start_compute;
        end
        checkOutput("t5 reached tile1 compute", 64'(found), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t5 abort busy", 64'(busy), 64'd0);
        checkOutput("t5 abort start_compute", 64'(bus.start_compute), 64'd0);
        checkOutput("t5 abort mc_start", 64'(bus.mc_start), 64'd0);
        checkOutput("t5 abort res_valid", 64'(bus.res_valid), 64'd0);
        checkOutput("t5 abort tile_cnt", 64'(tile_cnt), 64'd0);
        repeat (5) tick();
        checkOutput("t5 abort no done", 64'(done_cnt), 64'd0);
        cp_delay = 3;
        clearLogs();
        applyStimulus(5'd1, 32'h500);
        tick();
        checkOutput("t5 restart base", 64'(bus.mc_base_addr), 64'h500);
        waitDone("t5 restart done", 400);
        checkResults("t5 restart", 8);

        // Reset while draining, then restart.
        clearLogs();
        ready_mode = 3;
        applyStimulus(5'd2, 32'h600);
        n = 0;
        while (!bus.res_valid && n < 500) begin
            tick();
            n++;
        end
        checkOutput("t5b reached drain", 64'(bus.res_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t5b rst busy", 64'(busy), 64'd0);
        checkOutput("t5b rst res_valid", 64'(bus.res_valid), 64'd0);
        checkOutput("t5b rst res_idx", 64'(bus.res_idx), 64'd0);
        checkOutput("t5b rst res_data", 64'(bus.res_data), 64'd0);
        checkOutput("t5b rst done", 64'(done), 64'd0);
        ready_mode = 0;
        tick();
        clearLogs();
        applyStimulus(5'd1, 32'h600);
        waitDone("t5b restart done", 400);
        checkResults("t5b restart", 8);

        // Degenerate requests complete at once without datapath activity.
        clearLogs();
        applyStimulus(5'd0, 32'h700);
        checkOutput("t6 zero done", 64'(done), 64'd1);
        checkOutput("t6 zero busy", 64'(busy), 64'd0);
        checkOutput("t6 zero clr", 64'(bus.clr_accum), 64'd0);
        tick();
        checkOutput("t6 zero done pulse", 64'(done), 64'd0);
        applyStimulus(5'd17, 32'h700);
        checkOutput("t6 oversize done", 64'(done), 64'd1);
        checkOutput("t6 oversize busy", 64'(busy), 64'd0);
        repeat (3) tick();
        checkOutput("t6 no fetch", 64'(base_log.size()), 64'd0);
        checkOutput("t6 no clr", 64'(clr_cnt), 64'd0);

        // A go while busy must not disturb the run in progress.
        clearLogs();
        mc_delay = 10;
        applyStimulus(5'd1, 32'h800);
        tick();
        num_tiles = 5'd3;
        base_addr = 32'h900;
        go = 1'b1;
        tick();
        go = 1'b0;
        waitDone("t6 busy-go done", 400);
        repeat (3) tick();
        checkOutput("t6 busy-go done count", 64'(done_cnt), 64'd1);
        checkOutput("t6 busy-go fetch count", 64'(base_log.size()), 64'd1);
        checkBase("t6 busy-go base", 0, 32'h800);
        checkResults("t6 busy-go", 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end
endmodule
